// File: rtl/fpu_pkg.sv
// Shared constants and stage payload types for the FP normalizer.
package fpu_pkg;

   // Tag width carried in the stage payloads; the top's TAG_WIDTH is cast to this.
   localparam int unsigned TAG_W = 4;

   localparam logic signed [9:0] EXP_MIN  = -10'sd126;
   localparam logic signed [9:0] EXP_MAX  = 10'sd127;
   localparam logic signed [9:0] EXP_ZERO = -10'sd127;

   // Stage 1: raw payload plus leading-zero count of fraction[47:0].
   typedef struct packed {
      logic                    valid;
      logic                    sign;
      logic signed [9:0]       exponent;
      logic [48:0]             fraction;
      logic [5:0]              lzc;
      logic [TAG_W-1:0]        tag;
   } normalizer_stage_t;

   // Stage 2: normalized result as presented to the rounder.
   typedef struct packed {
      logic                    valid;
      logic                    sign;
      logic signed [9:0]       exponent;
      logic [23:0]             fraction;
      logic                    guard;
      logic                    round;
      logic                    sticky;
      logic                    zero;
      logic                    overflow;
      logic                    underflow;
      logic [TAG_W-1:0]        tag;
   } normalizer_out_t;

endpackage

// File: rtl/normalizer_leading_zero_counter.sv
// Leading-zero count of a 48-bit word (0..48) as a log2-depth normalize tree.
module normalizer_leading_zero_counter (
   input  logic [47:0] value_i,
   output logic [5:0]  count_o
);

   logic [63:0] work;

   // Pad with ones below so an all-zero input stops at exactly 48.
   always_comb begin
      work    = {value_i, 16'hffff};
      count_o = '0;
      if (work[63:32] == '0) begin
         count_o[5] = 1'b1;
         work       = work << 32;
      end
      if (work[63:48] == '0) begin
         count_o[4] = 1'b1;
         work       = work << 16;
      end
      if (work[63:56] == '0) begin
         count_o[3] = 1'b1;
         work       = work << 8;
      end
      if (work[63:60] == '0) begin
         count_o[2] = 1'b1;
         work       = work << 4;
      end
      if (work[63:62] == '0) begin
         count_o[1] = 1'b1;
         work       = work << 2;
      end
      if (!work[63]) begin
         count_o[0] = 1'b1;
      end
   end

endmodule

// File: rtl/normalizer.sv
// Post-add normalization: 2-stage valid/ready pipeline producing [x.23] + G/R/S.
// Optional: NORMALIZER_SUBNORMAL_EN keeps a denormal fraction on exponent underflow
// instead of flushing it to zero.
module normalizer
   import fpu_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [9:0]           in_exponent,
   input  logic [48:0]          in_fraction,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic [9:0]           out_exponent,
   output logic [23:0]          out_fraction,
   output logic                 out_guard,
   output logic                 out_round,
   output logic                 out_sticky,
   output logic                 out_zero,
   output logic                 out_overflow,
   output logic                 out_underflow,
   output logic [TAG_WIDTH-1:0] out_tag
);

   normalizer_stage_t s1_d, s1_q;
   normalizer_out_t   s2_d, s2_q;
   normalizer_out_t   res;
   logic [5:0]        lzc;
   logic              s2_load;
   logic signed [9:0] e;
   logic signed [9:0] exp_lz;
   logic [47:0]       norm;
   logic              spill;
`ifdef NORMALIZER_SUBNORMAL_EN
   logic signed [9:0] room;
`endif

   normalizer_leading_zero_counter u_lzc (
      .value_i (in_fraction[47:0]),
      .count_o (lzc)
   );

   // A stage loads when empty or when its contents move on this cycle.
   always_comb begin
      s2_load  = !s2_q.valid || out_ready;
      in_ready = !s1_q.valid || s2_load;
   end

   // Stage 1 next state: capture payload and its leading-zero count.
   always_comb begin
      s1_d = s1_q;
      if (in_ready) begin
         s1_d.valid = in_valid;
         if (in_valid) begin
            s1_d.sign     = in_sign;
            s1_d.exponent = in_exponent;
            s1_d.fraction = in_fraction;
            s1_d.lzc      = lzc;
            s1_d.tag      = TAG_W'(in_tag);
         end
      end
   end

   // Shift and exponent adjust of the stage 1 contents.
   always_comb begin
      e         = s1_q.exponent;
      exp_lz    = e - signed'({4'b0000, s1_q.lzc});
      norm      = '0;
      spill     = 1'b0;
      res       = '0;
      res.valid = 1'b1;
      res.sign  = s1_q.sign;
      res.tag   = s1_q.tag;
`ifdef NORMALIZER_SUBNORMAL_EN
      room      = e - EXP_MIN;
`endif
      if (s1_q.fraction == '0) begin
         res.zero     = 1'b1;
         res.exponent = EXP_ZERO;
      end else if (s1_q.fraction[48]) begin
         // Carry-out: shift right one, dropped bit joins sticky.
         norm         = s1_q.fraction[48:1];
         spill        = s1_q.fraction[0];
         res.exponent = e + 10'sd1;
      end else if (exp_lz < EXP_MIN) begin
         res.underflow = 1'b1;
         res.exponent  = EXP_ZERO;
`ifdef NORMALIZER_SUBNORMAL_EN
         // Shift only as far as the exponent allows, leaving a denormal.
         if (room > 10'sd0) begin
            norm = s1_q.fraction[47:0] << unsigned'(room);
         end else begin
            norm = s1_q.fraction[47:0];
         end
`endif
      end else begin
         norm         = s1_q.fraction[47:0] << s1_q.lzc;
         res.exponent = exp_lz;
      end
      res.overflow = $signed(res.exponent) > EXP_MAX;
      res.fraction = norm[47:24];
      res.guard    = norm[23];
      res.round    = norm[22];
      res.sticky   = (|norm[21:0]) | spill;
   end

   // Stage 2 next state: hold while stalled, otherwise take stage 1.
   always_comb begin
      s2_d = s2_q;
      if (s2_load) begin
         if (s1_q.valid) begin
            s2_d = res;
         end else begin
            s2_d.valid = 1'b0;
         end
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign out_valid     = s2_q.valid;
   assign out_sign      = s2_q.sign;
   assign out_exponent  = s2_q.exponent;
   assign out_fraction  = s2_q.fraction;
   assign out_guard     = s2_q.guard;
   assign out_round     = s2_q.round;
   assign out_sticky    = s2_q.sticky;
   assign out_zero      = s2_q.zero;
   assign out_overflow  = s2_q.overflow;
   assign out_underflow = s2_q.underflow;
   assign out_tag       = TAG_WIDTH'(s2_q.tag);

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: expected results queued at input handshake,
// popped and compared by an independent output monitor.
module tb_normalizer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [9:0]  in_exponent = '0;
   logic [48:0] in_fraction = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sign;
   logic [9:0]  out_exponent;
   logic [23:0] out_fraction;
   logic        out_guard;
   logic        out_round;
   logic        out_sticky;
   logic        out_zero;
   logic        out_overflow;
   logic        out_underflow;
   logic [3:0]  out_tag;

   normalizer #(.TAG_WIDTH(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exponent   (in_exponent),
      .in_fraction   (in_fraction),
      .in_tag        (in_tag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sign      (out_sign),
      .out_exponent  (out_exponent),
      .out_fraction  (out_fraction),
      .out_guard     (out_guard),
      .out_round     (out_round),
      .out_sticky    (out_sticky),
      .out_zero      (out_zero),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_tag       (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sign;
      logic [9:0]  exponent;
      logic [23:0] fraction;
      logic        guard;
      logic        round;
      logic        sticky;
      logic        zero;
      logic        overflow;
      logic        underflow;
      logic [3:0]  tag;
   } res_t;

   res_t exp_q[$];
   res_t held;
   res_t got;
   logic stalled = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   ready_mode = 0;
   int   pat_idx = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: locate the leading one, place it at the top of a wide window,
   // and read fraction/G/R/S straight out of that window.
   function automatic res_t model(input logic s, input logic [9:0] e, input logic [48:0] f,
                                  input logic [3:0] t);
      res_t         r;
      logic [95:0]  w;
      logic [95:0]  fw;
      int           p;
      int           ei;
      int           ex;
      int           sh;
      r      = '0;
      r.sign = s;
      r.tag  = t;
      ei     = $signed(e);
      if (f == '0) begin
         r.zero     = 1'b1;
         r.exponent = 10'h381;
         return r;
      end
      p = 0;
      for (int i = 0; i < 49; i++) if (f[i]) p = i;
      ex = ei + p - 47;
      fw = 96'(f);
      if (ex < -126) begin
         r.underflow = 1'b1;
         r.exponent  = 10'h381;
`ifdef NORMALIZER_SUBNORMAL_EN
         sh = ei + 126;
         if (sh < 0) sh = 0;
         w = fw << (48 + sh);
`else
         sh = 0;
         w  = '0;
`endif
      end else begin
         w          = fw << (95 - p);
         r.exponent = ex[9:0];
         r.overflow = ex > 127;
      end
      r.fraction = w[95:72];
      r.guard    = w[71];
      r.round    = w[70];
      r.sticky   = |w[69:0];
      return r;
   endfunction

   function automatic res_t actual();
      res_t r;
      r.sign      = out_sign;
      r.exponent  = out_exponent;
      r.fraction  = out_fraction;
      r.guard     = out_guard;
      r.round     = out_round;
      r.sticky    = out_sticky;
      r.zero      = out_zero;
      r.overflow  = out_overflow;
      r.underflow = out_underflow;
      r.tag       = out_tag;
      return r;
   endfunction

   function automatic logic [48:0] rand_frac();
      logic [63:0] r;
      logic [48:0] one;
      int          k;
      int          p;
      r   = {$urandom(), $urandom()};
      one = 49'd1;
      k   = $urandom_range(9);
      if (k == 0) return '0;
      if (k == 1) return r[48:0] | (one << 48);
      if (k == 2) return {2'b01, r[46:0]};
      p = $urandom_range(46);
      return (r[48:0] & ((one << p) - 49'd1)) | (one << p);
   endfunction

   function automatic logic [9:0] rand_exp();
      if ($urandom_range(3) == 0) return 10'($urandom_range(30)) - 10'd127;
      return 10'($urandom_range(255)) - 10'd127;
   endfunction

   // Downstream ready: always, random, or the repeating 1,0,0,1 pattern.
   always @(negedge clk) begin
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(1));
         default: begin
            out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            pat_idx++;
         end
      endcase
   end

   // Output monitor: pops on every output handshake, checks stability on stalls.
   always begin
      @(negedge clk);
      #4;
      if (!reset_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_payload", 64'(actual()), 64'(held));
         end
         stalled = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got tag %h, expected no output", out_tag);
               end else begin
                  got = exp_q.pop_front();
                  check("result", 64'(actual()), 64'(got));
               end
            end else begin
               held    = actual();
               stalled = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic s, input logic [9:0] e, input logic [48:0] f,
                       input logic [3:0] t);
      int   waited;
      logic ok;
      waited = 0;
      ok     = 1'b0;
      @(negedge clk);
      in_valid    = 1'b1;
      in_sign     = s;
      in_exponent = e;
      in_fraction = f;
      in_tag      = t;
      while (!ok) begin
         #4;
         if (in_ready) begin
            ok = 1'b1;
         end else if (waited > 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waited);
            in_valid = 1'b0;
            return;
         end else begin
            waited++;
            @(negedge clk);
         end
      end
      exp_q.push_back(model(s, e, f, t));
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      logic [63:0] r;
      repeat (n) begin
         @(negedge clk);
         r           = {$urandom(), $urandom()};
         in_valid    = 1'b0;
         in_fraction = r[48:0];
         in_tag      = r[52:49];
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #4;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_payload", 64'(actual()), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Two-cycle latency with a free-flowing output.
      send(1'b0, 10'd5, 49'h0_8000_0000_0000, 4'h1);
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      check("latency_cycle1", 64'(out_valid), 64'd0);
      @(negedge clk);
      #4;
      check("latency_cycle2", 64'(out_valid), 64'd1);
      idle(2);

      // Directed corners: carry-out overflow, deep shift, underflow, zero.
      send(1'b1, 10'd127, 49'h1_0000_0000_0001, 4'h2);
      send(1'b0, 10'd0, 49'h0_0000_0000_0001, 4'h3);
      send(1'b0, 10'h39c, 49'h0_0000_0000_0001, 4'h4);
      send(1'b1, 10'd20, 49'h0, 4'h5);
      send(1'b0, 10'h381, 49'h0_C000_0000_0123, 4'h6);
      send(1'b0, 10'h382, 49'h0_4000_0000_0007, 4'h7);
      send(1'b0, 10'd128, 49'h0_8000_0000_0000, 4'h8);
      idle(1);
      drain();

      // Back-to-back burst against the 1,0,0,1 ready pattern.
      pat_idx    = 0;
      ready_mode = 2;
      for (int i = 0; i < 8; i++) send(1'($urandom_range(1)), rand_exp(), rand_frac(), 4'(i));
      idle(1);
      drain();

      // Random traffic with random gaps and random backpressure.
      ready_mode = 1;
      for (int i = 0; i < 300; i++) begin
         send(1'($urandom_range(1)), rand_exp(), rand_frac(), 4'(i));
         if ($urandom_range(3) == 0) idle(1);
      end
      idle(1);
      ready_mode = 0;
      drain();

      // Reset with two operations in flight.
      send(1'b0, 10'd3, 49'h0_0F00_0000_0000, 4'h9);
      send(1'b1, 10'd4, 49'h0_00F0_0000_0000, 4'hA);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_async_valid", 64'(out_valid), 64'd0);
      exp_q.delete();
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("reset_release_ready", 64'(in_ready), 64'd1);
      repeat (4) begin
         @(negedge clk);
         #4;
         check("no_stale_output", 64'(out_valid), 64'd0);
      end
      send(1'b0, 10'd10, 49'h0_0000_1234_5678, 4'hB);
      idle(1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
